// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared definitions for the AD9222-style SPI register target.
// Holds the FSM state encoding, instruction field positions/widths and the
// W-field code that selects streaming mode.
package adc_spi_pkg;

    localparam int unsigned ADDR_W  = 13;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned INSTR_W = 16;

    // Instruction field positions (MSB first on the wire)
    localparam int unsigned RW_BIT = 15;
    localparam int unsigned W_MSB  = 14;
    localparam int unsigned W_LSB  = 13;

    // W1:W0 value meaning "stream bytes until CSBn deasserts"
    localparam logic [1:0] W_STREAM = 2'b11;

    typedef enum logic [2:0] {
        StIdle,
        StInstr,
        StWdata,
        StRdata,
        StDone
    } state_t;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with rise/fall pulse detection.
// Ports:
//   clk, rst  - system clock, asynchronous active-high reset
//   din       - asynchronous input
//   level     - synchronized level
//   rise/fall - one-clk pulses on synchronized edges
module spi_sync_edge #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] chain;
    logic              prev;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            chain <= {STAGES{RESET_VAL}};
            prev  <= RESET_VAL;
        end else begin
            chain <= {chain[STAGES-2:0], din};
            prev  <= chain[STAGES-1];
        end
    end

    assign level = chain[STAGES-1];
    assign rise  = level & ~prev;
    assign fall  = ~level & prev;

endmodule

// File: rtl/adc_spi_target.sv
// adc_spi_target: SPI target for an AD9222-style 3-wire register interface.
// A frame is a 16-bit instruction (R/Wn, W1:W0, 13-bit address) followed by
// data bytes; the address decrements after every byte.
// Ports:
//   clk, rst         - system clock, asynchronous active-high reset
//   AD9222_CSBn      - chip select (active low)
//   AD9222_SCLK      - serial clock, idle low
//   AD9222_SDIO      - bidirectional data, driven only while AD9222_SDIO_DIR=1
//   AD9222_SDIO_DIR  - 1 while the target drives read data
//   wr_en/wr_addr/wr_data - one-clk write strobe per received byte
//   rd_addr/rd_data  - read address out, register contents in
//   busy             - synchronized CSBn low
//   frame_err        - one-clk pulse on an aborted partial instruction/byte
module adc_spi_target
    import adc_spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              AD9222_CSBn,
    input  logic              AD9222_SCLK,
    inout  wire               AD9222_SDIO,
    output logic              AD9222_SDIO_DIR,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] rd_data,
    output logic              busy,
    output logic              frame_err
);

    logic sclk_level, sclk_rise, sclk_fall;
    logic csb_level, csb_rise, csb_fall;
    logic unused_sclk_level;

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sclk_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (AD9222_SCLK),
        .level (sclk_level),
        .rise  (sclk_rise),
        .fall  (sclk_fall)
    );

    spi_sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_csb_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (AD9222_CSBn),
        .level (csb_level),
        .rise  (csb_rise),
        .fall  (csb_fall)
    );

    assign unused_sclk_level = sclk_level;

    // Same depth as SCLK so data and clock stay aligned after synchronization
    logic [SYNC_STAGES-1:0] sdio_chain;
    logic                   sdio_s;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sdio_chain <= '0;
        end else begin
            sdio_chain <= {sdio_chain[SYNC_STAGES-2:0], AD9222_SDIO};
        end
    end

    assign sdio_s = sdio_chain[SYNC_STAGES-1];

    state_t               state;
    logic [3:0]           bit_cnt;
    logic [1:0]           byte_cnt;
    logic [1:0]           w_field;
    logic [ADDR_W-1:0]    addr;
    logic [INSTR_W-2:0]   shift;
    logic [DATA_W-1:0]    rd_shift;
    logic                 sdio_dir;

    logic [INSTR_W-1:0]   shift_next;
    logic                 last_byte;
    logic                 partial;

    assign shift_next = {shift, sdio_s};
    assign last_byte  = (w_field != W_STREAM) && (byte_cnt == w_field);
    // Any bits collected since the last byte boundary mean the frame was cut short
    assign partial    = (state == StInstr || state == StWdata || state == StRdata) &&
                        (bit_cnt != 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= StIdle;
            bit_cnt   <= '0;
            byte_cnt  <= '0;
            w_field   <= '0;
            addr      <= '0;
            shift     <= '0;
            rd_shift  <= '0;
            sdio_dir  <= 1'b0;
            wr_en     <= 1'b0;
            wr_addr   <= '0;
            wr_data   <= '0;
            rd_addr   <= '0;
            frame_err <= 1'b0;
        end else begin
            wr_en     <= 1'b0;
            frame_err <= 1'b0;
            if (csb_rise) begin
                frame_err <= partial;
                state     <= StIdle;
                sdio_dir  <= 1'b0;
                bit_cnt   <= '0;
            end else begin
                unique case (state)
                    StIdle: begin
                        if (csb_fall) begin
                            state   <= StInstr;
                            bit_cnt <= '0;
                        end
                    end
                    StInstr: begin
                        if (sclk_rise) begin
                            shift <= shift_next[INSTR_W-2:0];
                            if (bit_cnt == 4'(INSTR_W - 1)) begin
                                w_field  <= shift_next[W_MSB:W_LSB];
                                addr     <= shift_next[ADDR_W-1:0];
                                bit_cnt  <= '0;
                                byte_cnt <= '0;
                                if (shift_next[RW_BIT]) begin
                                    state   <= StRdata;
                                    rd_addr <= shift_next[ADDR_W-1:0];
                                end else begin
                                    state <= StWdata;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    StWdata: begin
                        if (sclk_rise) begin
                            shift <= shift_next[INSTR_W-2:0];
                            if (bit_cnt == 4'(DATA_W - 1)) begin
                                wr_en    <= 1'b1;
                                wr_addr  <= addr;
                                wr_data  <= shift_next[DATA_W-1:0];
                                addr     <= addr - 1'b1;
                                bit_cnt  <= '0;
                                byte_cnt <= byte_cnt + 2'd1;
                                if (last_byte) begin
                                    state <= StDone;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    StRdata: begin
                        if (sclk_fall) begin
                            // Falling edge at a byte boundary loads the next byte,
                            // otherwise shifts the next bit onto SDIO
                            sdio_dir <= 1'b1;
                            if (bit_cnt == 4'd0) begin
                                rd_shift <= rd_data;
                            end else begin
                                rd_shift <= {rd_shift[DATA_W-2:0], 1'b0};
                            end
                        end else if (sclk_rise) begin
                            if (bit_cnt == 4'(DATA_W - 1)) begin
                                bit_cnt  <= '0;
                                byte_cnt <= byte_cnt + 2'd1;
                                if (last_byte) begin
                                    state    <= StDone;
                                    sdio_dir <= 1'b0;
                                end else begin
                                    addr    <= addr - 1'b1;
                                    rd_addr <= addr - 1'b1;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 4'd1;
                            end
                        end
                    end
                    StDone: begin
                        // SCLK activity ignored until CSBn rises
                    end
                    default: state <= StIdle;
                endcase
            end
        end
    end

    assign AD9222_SDIO     = sdio_dir ? rd_shift[DATA_W-1] : 1'bz;
    assign AD9222_SDIO_DIR = sdio_dir;
    assign busy            = ~csb_level;

endmodule

// File: tb/tb_adc_spi_target.sv
// tb_adc_spi_target: randomized + directed bench for adc_spi_target.
// An initiator task bit-bangs frames; a negedge monitor collects write strobes,
// frame_err pulses and drive cycles; a frame-level model derives the expected
// strobes, read bytes and error flag from the frame's length and fields.
module tb_adc_spi_target;

    localparam int HALF = 8;  // clk periods per SCLK phase

    logic        clk = 1'b0;
    logic        rst;
    logic        csbn;
    logic        sclk;
    wire         sdio;
    logic        sdio_dir;
    logic        wr_en;
    logic [12:0] wr_addr;
    logic [7:0]  wr_data;
    logic [12:0] rd_addr;
    logic [7:0]  rd_data;
    logic        busy;
    logic        frame_err;

    logic        drv_en;
    logic        drv_val;
    assign sdio = drv_en ? drv_val : 1'bz;

    logic [7:0] mem [8192];
    assign rd_data = mem[rd_addr];

    always #5 clk = ~clk;

    adc_spi_target #(.SYNC_STAGES(2)) dut (
        .clk             (clk),
        .rst             (rst),
        .AD9222_CSBn     (csbn),
        .AD9222_SCLK     (sclk),
        .AD9222_SDIO     (sdio),
        .AD9222_SDIO_DIR (sdio_dir),
        .wr_en           (wr_en),
        .wr_addr         (wr_addr),
        .wr_data         (wr_data),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .busy            (busy),
        .frame_err       (frame_err)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [12:0] a;
        logic [7:0]  d;
    } wr_t;

    wr_t        obs[$];
    int         err_pulses;
    int         dir_clks;
    logic [7:0] wdata [16];
    logic [7:0] rbytes[$];
    logic       dirs[$];

    always @(negedge clk) begin
        if (wr_en)     obs.push_back(wr_t'{a: wr_addr, d: wr_data});
        if (frame_err) err_pulses++;
        if (sdio_dir)  dir_clks++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_wr_en"},     32'(wr_en),     32'd0);
        check_eq({tag, "_wr_addr"},   32'(wr_addr),   32'd0);
        check_eq({tag, "_wr_data"},   32'(wr_data),   32'd0);
        check_eq({tag, "_rd_addr"},   32'(rd_addr),   32'd0);
        check_eq({tag, "_busy"},      32'(busy),      32'd0);
        check_eq({tag, "_frame_err"}, 32'(frame_err), 32'd0);
        check_eq({tag, "_sdio_dir"},  32'(sdio_dir),  32'd0);
    endtask

    // Drive one frame of nbits SCLK cycles; rst_bit >= 0 resets the DUT at that bit.
    task automatic send_frame(input logic rw, input logic [1:0] w, input logic [12:0] a,
                              input int nbits, input int rst_bit);
        logic [15:0] instr;
        logic [7:0]  rb;
        logic        dir_ok;
        instr = {rw, w, a};
        rb = '0;
        dir_ok = 1'b1;
        obs.delete();
        rbytes.delete();
        dirs.delete();
        err_pulses = 0;
        dir_clks   = 0;
        csbn = 1'b0;
        wait_clks(HALF);
        check_eq("busy_in_frame", 32'(busy), 32'd1);
        for (int i = 0; i < nbits; i++) begin
            if (i == rst_bit) begin
                rst = 1'b1;
                wait_clks(2);
                check_reset_outputs("mid_rst");
                csbn   = 1'b1;
                drv_en = 1'b0;
                wait_clks(2);
                rst = 1'b0;
                wait_clks(6);
                return;
            end
            if (i < 16) begin
                drv_en  = 1'b1;
                drv_val = instr[15-i];
            end else if (!rw) begin
                drv_en  = 1'b1;
                drv_val = wdata[((i - 16) / 8) % 16][7 - ((i - 16) % 8)];
            end else begin
                drv_en = 1'b0;
            end
            wait_clks(HALF);
            if (i >= 16 && rw) begin
                if ((i - 16) % 8 == 0) dir_ok = 1'b1;
                rb     = {rb[6:0], sdio};
                dir_ok = dir_ok & sdio_dir;
                if ((i - 16) % 8 == 7) begin
                    rbytes.push_back(rb);
                    dirs.push_back(dir_ok);
                end
            end
            sclk = 1'b1;
            wait_clks(HALF);
            sclk = 1'b0;
        end
        drv_en = 1'b0;
        wait_clks(HALF);
        csbn = 1'b1;
        wait_clks(10);
    endtask

    // Frame-level reference: bytes counted from W, address decrementing mod 2^13
    task automatic check_frame(input logic rw, input logic [1:0] w, input logic [12:0] a,
                               input int nbits);
        int          data_bits;
        int          full;
        int          part;
        int          cnt;
        logic        exp_err;
        logic [12:0] ea;
        data_bits = (nbits > 16) ? nbits - 16 : 0;
        full = data_bits / 8;
        part = data_bits % 8;
        if (w == 2'd3) cnt = full;
        else           cnt = (full < int'(w) + 1) ? full : int'(w) + 1;
        exp_err = (nbits > 0 && nbits < 16) ||
                  (nbits >= 16 && part != 0 && (w == 2'd3 || full < int'(w) + 1));
        check_eq("frame_err_cnt", 32'(err_pulses), 32'(exp_err));
        check_eq("sdio_dir_after", 32'(sdio_dir), 32'd0);
        check_eq("busy_after", 32'(busy), 32'd0);
        if (!rw) begin
            check_eq("wr_count", 32'(obs.size()), 32'(cnt));
            check_eq("no_drive_on_write", 32'(dir_clks), 32'd0);
            for (int i = 0; i < cnt && i < obs.size(); i++) begin
                ea = a - 13'(i);
                check_eq("wr_addr", 32'(obs[i].a), 32'(ea));
                check_eq("wr_data", 32'(obs[i].d), 32'(wdata[i]));
            end
        end else begin
            check_eq("wr_count_on_read", 32'(obs.size()), 32'd0);
            for (int i = 0; i < cnt && i < rbytes.size(); i++) begin
                ea = a - 13'(i);
                check_eq("rd_byte", 32'(rbytes[i]), 32'(mem[ea]));
                check_eq("rd_dir", 32'(dirs[i]), 32'd1);
            end
        end
    endtask

    initial begin
        logic        rw;
        logic [1:0]  w;
        logic [12:0] a;
        int          nbytes;
        int          nbits;

        rst    = 1'b1;
        csbn   = 1'b1;
        sclk   = 1'b0;
        drv_en = 1'b0;
        drv_val = 1'b0;
        for (int i = 0; i < 8192; i++) mem[i] = 8'($urandom);
        wait_clks(4);
        check_reset_outputs("reset");
        rst = 1'b0;
        wait_clks(4);

        // Single-byte write
        wdata[0] = 8'h04;
        send_frame(1'b0, 2'd0, 13'h00D, 24, -1);
        check_frame(1'b0, 2'd0, 13'h00D, 24);

        // Single-byte read of 0xA5
        mem[1] = 8'hA5;
        send_frame(1'b1, 2'd0, 13'h001, 24, -1);
        check_frame(1'b1, 2'd0, 13'h001, 24);
        check_eq("rd_addr_read1", 32'(rd_addr), 32'h001);
        check_eq("rd_byte_a5", 32'(rbytes[0]), 32'hA5);

        // Two-byte write wrapping 0x000 -> 0x1FFF
        wdata[0] = 8'h11;
        wdata[1] = 8'h22;
        send_frame(1'b0, 2'd1, 13'h000, 32, -1);
        check_frame(1'b0, 2'd1, 13'h000, 32);

        // Streaming write of 3 bytes ending on a byte boundary
        wdata[2] = 8'h33;
        send_frame(1'b0, 2'd3, 13'h0FF, 40, -1);
        check_frame(1'b0, 2'd3, 13'h0FF, 40);

        // Aborts: partial instruction, partial data byte
        send_frame(1'b0, 2'd0, 13'h055, 10, -1);
        check_frame(1'b0, 2'd0, 13'h055, 10);
        send_frame(1'b0, 2'd0, 13'h055, 19, -1);
        check_frame(1'b0, 2'd0, 13'h055, 19);

        // Extra SCLKs after the counted byte are ignored
        send_frame(1'b0, 2'd0, 13'h123, 40, -1);
        check_frame(1'b0, 2'd0, 13'h123, 40);

        // Reset mid-write, then a clean write
        send_frame(1'b0, 2'd0, 13'h0AA, 24, 20);
        check_eq("rst_no_wr", 32'(obs.size()), 32'd0);
        check_eq("rst_no_err", 32'(err_pulses), 32'd0);
        wdata[0] = 8'h03;
        send_frame(1'b0, 2'd0, 13'h008, 24, -1);
        check_frame(1'b0, 2'd0, 13'h008, 24);

        // Randomized frames
        for (int t = 0; t < 24; t++) begin
            rw = 1'($urandom);
            w  = 2'($urandom);
            a  = 13'($urandom);
            for (int k = 0; k < 16; k++) wdata[k] = 8'($urandom);
            nbytes = (w == 2'd3) ? int'($urandom_range(1, 4)) : int'(w) + 1;
            if ($urandom_range(0, 3) == 0) nbytes++;
            nbits = 16 + 8 * nbytes;
            if ($urandom_range(0, 3) == 0) nbits = int'($urandom_range(1, nbits - 1));
            send_frame(rw, w, a, nbits, -1);
            check_frame(rw, w, a, nbits);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
